// File: rtl/log2_fx_pkg.sv
// log2_fx_pkg
//   Shared definitions for the pipelined fixed-point log2 unit: format
//   helpers derived from DATA_WIDTH, the internal mantissa width, the stage
//   payload struct and the leading-one detector.
//   Widths are sized for DATA_WIDTH up to DW_MAX so that one struct type
//   serves every legal instance; narrower instances leave upper bits at zero.
package log2_fx_pkg;

    localparam int DW_MAX  = 16;
    localparam int E_W     = $clog2(DW_MAX);
    // Mantissa is 1 integer bit plus MANT_F fraction bits. 2*DW_MAX fraction
    // bits keep repeated squaring exact enough for every operand to floor
    // correctly.
    localparam int MANT_F  = 2 * DW_MAX;
    localparam int MANT_W  = MANT_F + 1;
    localparam int SQ_W    = 2 * MANT_W;
    // Square re-aligned to MANT_F fraction bits: 2 integer bits + MANT_F.
    localparam int SQ_HI_W = MANT_W + 1;

    typedef struct packed {
        logic [E_W-1:0]    e;     // integer part (index of leading one)
        logic [DW_MAX-1:0] frac;  // fraction bits collected so far, LSB newest
        logic              zero;  // operand was zero
        logic [MANT_W-1:0] mant;  // mantissa in [1,2), Q1.MANT_F
    } stage_t;

    function automatic int int_w_of(input int dw);
        return $clog2(dw);
    endfunction

    function automatic int frac_w_of(input int dw);
        return dw - $clog2(dw);
    endfunction

    function automatic int latency_of(input int dw);
        return frac_w_of(dw) + 1;
    endfunction

    // Index of the most significant set bit; 0 for a zero operand.
    function automatic logic [E_W-1:0] lead_one(input logic [DW_MAX-1:0] v);
        logic [E_W-1:0] idx;
        idx = {E_W{1'b0}};
        for (int i = 0; i < DW_MAX; i++) begin
            idx = v[i] ? E_W'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/log2_fx_sq_stage.sv
// log2_fx_sq_stage
//   One fraction-bit stage of the log2 pipeline. Squares the incoming
//   mantissa; a square >= 2 yields fraction bit 1 and is halved, otherwise
//   bit 0 and the square is kept. The payload is registered on the way out.
//   Ports:
//     clk_i       clock, rising edge
//     rstn_i      synchronous active-high reset, clears the payload
//     prev_stage  payload from the previous stage
//     next_stage  registered payload for the next stage
module log2_fx_sq_stage
    import log2_fx_pkg::*;
(
    input  logic   clk_i,
    input  logic   rstn_i,
    input  stage_t prev_stage,
    output stage_t next_stage
);

    logic [SQ_W-1:0]    mant_ext_s;
    logic [SQ_HI_W-1:0] sq_hi_s;
    stage_t             nxt_s;
    stage_t             stage_r;

    // Square the mantissa and derive the next fraction bit and mantissa.
    always_comb begin
        nxt_s      = prev_stage;
        mant_ext_s = {{MANT_W{1'b0}}, prev_stage.mant};
        // Drop the low MANT_F bits of the square: truncation back to Q2.MANT_F.
        sq_hi_s    = SQ_HI_W'((mant_ext_s * mant_ext_s) >> MANT_F);
        if (prev_stage.zero) begin
            // Keep a zero operand's payload all-zero so it reaches the output as 0.
            nxt_s      = '0;
            nxt_s.zero = 1'b1;
        end else if (sq_hi_s[SQ_HI_W-1]) begin
            nxt_s.mant = sq_hi_s[SQ_HI_W-1:1];
            nxt_s.frac = {prev_stage.frac[DW_MAX-2:0], 1'b1};
        end else begin
            nxt_s.mant = sq_hi_s[MANT_W-1:0];
            nxt_s.frac = {prev_stage.frac[DW_MAX-2:0], 1'b0};
        end
    end

    // Stage payload register.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            stage_r <= '0;
        end else begin
            stage_r <= nxt_s;
        end
    end

    assign next_stage = stage_r;

endmodule

// File: rtl/log2_fx.sv
// log2_fx
//   Pipelined fixed-point base-2 logarithm. number_o = floor(log2(x)*2^FRAC_W)
//   in unsigned Q(INT_W).(FRAC_W); a zero operand gives 0. One operand per
//   clock, result FRAC_W+1 register stages later. DATA_WIDTH must lie in
//   2..DW_MAX.
//   Ports:
//     clk_i     clock, rising edge
//     rstn_i    synchronous active-high reset, clears every pipeline register
//     number_i  unsigned operand, sampled every rising edge
//     number_o  log2 result: [DATA_WIDTH-1:FRAC_W] integer, [FRAC_W-1:0] fraction
module log2_fx
    import log2_fx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] number_i,
    output logic [DATA_WIDTH-1:0] number_o
);

    localparam int INT_W  = int_w_of(DATA_WIDTH);
    localparam int FRAC_W = frac_w_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] num_r;
    logic [DW_MAX-1:0]     num_ext_s;
    logic [E_W-1:0]        lead_s;
    stage_t                stage0_s;
    stage_t                link_s [FRAC_W+1];
    stage_t                last_s;
    logic                  unused_s;

    // Input register.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            num_r <= {DATA_WIDTH{1'b0}};
        end else begin
            num_r <= number_i;
        end
    end

    // Leading-one detect and normalisation of the registered operand.
    always_comb begin
        num_ext_s     = DW_MAX'(num_r);
        lead_s        = lead_one(num_ext_s);
        stage0_s      = '0;
        stage0_s.e    = lead_s;
        stage0_s.zero = (num_r == {DATA_WIDTH{1'b0}});
        // m = x / 2^e placed as Q1.MANT_F; exact because e < MANT_F.
        stage0_s.mant = MANT_W'({num_ext_s, {MANT_F{1'b0}}} >> lead_s);
    end

    assign link_s[0] = stage0_s;

    for (genvar g = 0; g < FRAC_W; g++) begin : g_sq
        log2_fx_sq_stage u_sq (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .prev_stage (link_s[g]),
            .next_stage (link_s[g+1])
        );
    end

    assign last_s = link_s[FRAC_W];

    // Last stage register already carries the finished fraction and a zeroed
    // payload for zero operands, so the result is taken straight from flops.
    assign number_o = {last_s.e[INT_W-1:0], last_s.frac[FRAC_W-1:0]};

    // Mantissa, zero flag and spare bits of the final payload are not needed.
    assign unused_s = ^last_s;

endmodule

// File: tb/tb_log2_fx.sv
// tb_log2_fx
//   Directed self-checking bench for log2_fx at DATA_WIDTH = 8 (Q3.5).
module tb_log2_fx;

    logic       clk;
    logic       rst;
    logic [7:0] num;
    logic [7:0] res;

    int checks_cnt;
    int errors_cnt;

    log2_fx #(.DATA_WIDTH(8)) dut (
        .clk_i    (clk),
        .rstn_i   (rst),
        .number_i (num),
        .number_o (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // floor(log2(x) * 32); tiny epsilon keeps exact powers of two from flooring low.
    function automatic logic [7:0] ref_log2(input int x);
        real r;
        if (x == 0) return 8'd0;
        r = $ln(real'(x)) / $ln(2.0) * 32.0 + 1.0e-6;
        return 8'($rtoi($floor(r)));
    endfunction

    task automatic hold_and_check(input string tag, input logic [7:0] x, input logic [7:0] exp);
        num = x;
        repeat (7) step();
        check_eq(tag, res, exp);
        step();
        check_eq({tag, "_stable"}, res, exp);
    endtask

    logic [7:0] np_in  [5] = '{8'd3, 8'd5, 8'd10, 8'd255, 8'd200};
    logic [7:0] np_exp [5] = '{8'd50, 8'd74, 8'd106, 8'd255, 8'd244};

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        num = 8'd200;

        // Reset held for two edges, then flush, then first result.
        step();
        check_eq("rst_0", res, 8'd0);
        step();
        check_eq("rst_1", res, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("flush", res, 8'd0);
        end
        step();
        check_eq("first_200", res, 8'd244);

        // Powers of two.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] p;
            logic [7:0] e;
            p = 8'd1 << k;
            e = 8'(k * 32);
            hold_and_check("pow2", p, e);
        end

        // Non-powers, hand-computed.
        for (int i = 0; i < 5; i++) begin
            hold_and_check("nonpow", np_in[i], np_exp[i]);
        end

        // Zero operand after a large one.
        hold_and_check("zero", 8'd0, 8'd0);

        // Exhaustive held sweep against the bench model.
        for (int x = 1; x < 256; x++) begin
            num = 8'(x);
            repeat (7) step();
            check_eq("sweep", res, ref_log2(x));
        end

        // Back-to-back stream 1..255: result of the value driven before edge i
        // appears after edge i+5.
        for (int i = 0; i < 255 + 5; i++) begin
            num = (i < 255) ? 8'(i + 1) : 8'd0;
            step();
            if (i >= 5) begin
                check_eq("b2b", res, ref_log2(i - 5 + 1));
            end
        end

        // Reset in the middle of a stream discards in-flight operands.
        for (int i = 0; i < 20; i++) begin
            num = 8'(100 + i);
            step();
        end
        rst = 1'b1;
        num = 8'd150;
        step();
        check_eq("mid_rst", res, 8'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            num = 8'(160 + k);
            step();
            check_eq("mid_flush", res, 8'd0);
        end
        for (int k = 5; k < 10; k++) begin
            num = 8'(160 + k);
            step();
            check_eq("mid_resume", res, ref_log2(160 + k - 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
